imem_loader: RTL and testbench

- Program loader: the writer side of the instruction memory that the fetch stage reads by word address.
- Accepts a byte stream over a valid/ready handshake and packs bytes little-endian into 32-bit instruction words.
- Writes each word to consecutive instruction-memory addresses starting at 0.
- Holds the core in a hold state while loading and signals completion.

---
 rtl/imem_loader.sv | 159 +++++++++++++++
 tb/tb_imem_loader.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: byte-stream program loader that packs little-endian bytes into
// 32-bit words and writes them to instruction memory from address 0 upward,
// holding the core off fetch while the load is in progress.
module imem_loader #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   len_words,
    input  logic              abort,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              core_hold,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int unsigned LEN_W  = ADDR_W + 1;
    localparam int unsigned BUF_W  = 24;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [1:0]          idx_q, idx_d;
    logic [BUF_W-1:0]    buf_q, buf_d;

    logic                byte_ready_d;
    logic                mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_d;
    logic [31:0]         mem_wdata_d;
    logic                core_hold_d;
    logic                busy_d;
    logic                done_d;
    logic                error_d;
    logic [LEN_W-1:0]    words_loaded_d;

    logic                accept_c;
    logic                len_bad_c;

    // A byte transfers only while the registered ready is high.
    assign accept_c  = byte_valid && byte_ready;
    assign len_bad_c = (len_words == LEN_W'(0)) || (len_words > LEN_W'(DEPTH));

    // Next-state and next-output logic; every output is registered from here.
    always_comb begin
        state_d        = state_q;
        len_d          = len_q;
        idx_d          = idx_q;
        buf_d          = buf_q;
        mem_addr_d     = mem_addr;
        mem_wdata_d    = mem_wdata;
        error_d        = error;
        words_loaded_d = words_loaded;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    if (len_bad_c) begin
                        error_d = 1'b1;
                    end else begin
                        len_d          = len_words;
                        error_d        = 1'b0;
                        words_loaded_d = '0;
                        idx_d          = '0;
                        buf_d          = '0;
                        state_d        = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (abort) begin
                    idx_d   = '0;
                    buf_d   = '0;
                    state_d = S_IDLE;
                end else if (accept_c) begin
                    if (idx_q == 2'd3) begin
                        // Final byte lands in [31:24]; earlier bytes were shifted down into place.
                        mem_wdata_d = {byte_in, buf_q};
                        mem_addr_d  = words_loaded[ADDR_W-1:0];
                        idx_d       = '0;
                        buf_d       = '0;
                        state_d     = S_WRITE;
                    end else begin
                        buf_d = {byte_in, buf_q[BUF_W-1:8]};
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            S_WRITE: begin
                // The write strobe for this cycle is already committed; abort only suppresses the count.
                if (abort) begin
                    idx_d   = '0;
                    buf_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    words_loaded_d = words_loaded + LEN_W'(1);
                    state_d        = (words_loaded_d == len_q) ? S_DONE : S_LOAD;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        byte_ready_d = (state_d == S_LOAD);
        mem_we_d     = (state_d == S_WRITE);
        core_hold_d  = (state_d == S_LOAD) || (state_d == S_WRITE);
        busy_d       = core_hold_d;
        done_d       = (state_d == S_DONE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            len_q        <= '0;
            idx_q        <= '0;
            buf_q        <= '0;
            byte_ready   <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            core_hold    <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            idx_q        <= idx_d;
            buf_q        <= buf_d;
            byte_ready   <= byte_ready_d;
            mem_we       <= mem_we_d;
            mem_addr     <= mem_addr_d;
            mem_wdata    <= mem_wdata_d;
            core_hold    <= core_hold_d;
            busy         <= busy_d;
            done         <= done_d;
            error        <= error_d;
            words_loaded <= words_loaded_d;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: drives the byte stream on the falling edge
// and checks registered outputs there, with a monitor logging memory writes.
module tb_imem_loader;

    localparam int unsigned ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W:0]   len_words;
    logic              abort;
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              core_hold;
    logic              busy;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   words_loaded;

    int n_cmp = 0;
    int n_bad = 0;

    logic [ADDR_W-1:0] wr_addr[$];
    logic [31:0]       wr_data[$];
    int                rdy_bad = 0;

    always #5 clk = ~clk;

    imem_loader #(.ADDR_W(ADDR_W), .DEPTH(256)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .len_words    (len_words),
        .abort        (abort),
        .byte_in      (byte_in),
        .byte_valid   (byte_valid),
        .byte_ready   (byte_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .core_hold    (core_hold),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    // Write log: one entry per cycle with mem_we high.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_wdata);
            if (byte_ready !== 1'b0) rdy_bad++;
        end
    end

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
    endtask

    // Offer one byte; returns on the falling edge after it was taken.
    task automatic send_byte(input logic [7:0] b, output bit ok);
        ok = 1'b0;
        byte_in    = b;
        byte_valid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            if (byte_ready === 1'b1) begin
                @(negedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic send_word(input logic [31:0] w, input bit gap, output bit ok);
        bit o;
        ok = 1'b1;
        for (int k = 0; k < 4; k++) begin
            send_byte(w[8*k +: 8], o);
            if (!o) ok = 1'b0;
            if (gap) begin
                byte_valid = 1'b0;
                @(negedge clk);
            end
        end
    endtask

    task automatic start_load(input logic [ADDR_W:0] len);
        start     = 1'b1;
        len_words = len;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b1; len_words = 9'd1; abort = 1'b0;
        byte_in = 8'h55; byte_valid = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({byte_ready, mem_we, core_hold, busy, done, error} !== 6'b0) begin
            n_bad++;
            $display("FAIL reset_flags: got %b want 000000", {byte_ready, mem_we, core_hold, busy, done, error});
        end
        n_cmp++;
        if (mem_addr !== 8'h00) begin n_bad++; $display("FAIL reset_addr: got %h want 00", mem_addr); end
        n_cmp++;
        if (mem_wdata !== 32'h0) begin n_bad++; $display("FAIL reset_wdata: got %h want 0", mem_wdata); end
        n_cmp++;
        if (words_loaded !== 9'd0) begin n_bad++; $display("FAIL reset_words: got %0d want 0", words_loaded); end
        start = 1'b0;
        rst   = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (byte_ready !== 1'b0) begin n_bad++; $display("FAIL reset_release_ready: got %b want 0", byte_ready); end
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_release_busy: got %b want 0", busy); end
        byte_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        bit o;
        bit all_ok;
        logic [7:0] bytes [4];
        bytes = '{8'h13, 8'h05, 8'h10, 8'h00};
        all_ok = 1'b1;
        clear_log();
        start_load(9'd1);
        for (int k = 0; k < 4; k++) begin
            send_byte(bytes[k], o);
            if (!o) all_ok = 1'b0;
        end
        n_cmp++;
        if (all_ok !== 1'b1) begin n_bad++; $display("FAIL single_accept: got %b want 1", all_ok); end
        n_cmp++;
        if ({mem_we, byte_ready} !== 2'b10) begin
            n_bad++; $display("FAIL single_latency: we/ready got %b want 10", {mem_we, byte_ready});
        end
        byte_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (wr_addr.size() !== 1) begin n_bad++; $display("FAIL single_count: got %0d want 1", wr_addr.size()); end
        else begin
            n_cmp++;
            if (wr_addr[0] !== 8'h00 || wr_data[0] !== 32'h00100513) begin
                n_bad++; $display("FAIL single_write: got %h/%h want 00/00100513", wr_addr[0], wr_data[0]);
            end
        end
        n_cmp++;
        if ({done, core_hold, busy} !== 3'b100) begin
            n_bad++; $display("FAIL single_done: done/hold/busy got %b want 100", {done, core_hold, busy});
        end
        n_cmp++;
        if (words_loaded !== 9'd1) begin n_bad++; $display("FAIL single_words: got %0d want 1", words_loaded); end
    endtask

    task automatic test_three_toggle();
        bit o;
        bit all_ok;
        logic [31:0] words [3];
        words = '{32'h00000093, 32'h00108113, 32'hFE000EE3};
        all_ok = 1'b1;
        clear_log();
        rdy_bad = 0;
        start_load(9'd3);
        for (int w = 0; w < 3; w++) begin
            send_word(words[w], 1'b1, o);
            if (!o) all_ok = 1'b0;
        end
        byte_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (all_ok !== 1'b1) begin n_bad++; $display("FAIL three_accept: got %b want 1", all_ok); end
        n_cmp++;
        if (wr_addr.size() !== 3) begin n_bad++; $display("FAIL three_count: got %0d want 3", wr_addr.size()); end
        else begin
            for (int w = 0; w < 3; w++) begin
                n_cmp++;
                if (wr_addr[w] !== 8'(w) || wr_data[w] !== words[w]) begin
                    n_bad++;
                    $display("FAIL three_write%0d: got %h/%h want %h/%h", w, wr_addr[w], wr_data[w], 8'(w), words[w]);
                end
            end
        end
        n_cmp++;
        if (rdy_bad !== 0) begin n_bad++; $display("FAIL three_ready_in_write: got %0d want 0", rdy_bad); end
        n_cmp++;
        if ({done, words_loaded} !== {1'b1, 9'd3}) begin
            n_bad++; $display("FAIL three_done: got %b/%0d want 1/3", done, words_loaded);
        end
    endtask

    task automatic test_bad_len();
        bit o;
        do_reset();
        clear_log();
        start_load(9'd0);
        n_cmp++;
        if ({error, busy, done} !== 3'b100) begin
            n_bad++; $display("FAIL badlen_zero: err/busy/done got %b want 100", {error, busy, done});
        end
        start_load(9'd257);
        @(negedge clk);
        n_cmp++;
        if ({error, busy, done, byte_ready} !== 4'b1000) begin
            n_bad++; $display("FAIL badlen_257: err/busy/done/ready got %b want 1000", {error, busy, done, byte_ready});
        end
        n_cmp++;
        if (wr_addr.size() !== 0) begin n_bad++; $display("FAIL badlen_nowrite: got %0d want 0", wr_addr.size()); end
        start_load(9'd2);
        n_cmp++;
        if ({error, busy, byte_ready} !== 3'b011) begin
            n_bad++; $display("FAIL badlen_recover: err/busy/ready got %b want 011", {error, busy, byte_ready});
        end
        send_word(32'h04030201, 1'b0, o);
        send_word(32'h08070605, 1'b0, o);
        byte_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (wr_addr.size() !== 2) begin n_bad++; $display("FAIL badlen_count: got %0d want 2", wr_addr.size()); end
        else begin
            n_cmp++;
            if (wr_data[0] !== 32'h04030201 || wr_data[1] !== 32'h08070605 || wr_addr[1] !== 8'h01) begin
                n_bad++;
                $display("FAIL badlen_data: got %h %h @%h want 04030201 08070605 @01", wr_data[0], wr_data[1], wr_addr[1]);
            end
        end
        // Rejected start while DONE leaves done and state alone.
        start_load(9'd300);
        n_cmp++;
        if ({error, done, busy, words_loaded} !== {3'b110, 9'd2}) begin
            n_bad++; $display("FAIL badlen_in_done: err/done/busy/words got %b%b%b/%0d want 110/2", error, done, busy, words_loaded);
        end
    endtask

    task automatic test_abort();
        bit o;
        clear_log();
        start_load(9'd4);
        n_cmp++;
        if (error !== 1'b0) begin n_bad++; $display("FAIL abort_err_clear: got %b want 0", error); end
        send_word(32'h44332211, 1'b0, o);
        send_byte(8'h55, o);
        send_byte(8'h66, o);
        byte_valid = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_cmp++;
        if ({busy, core_hold, done} !== 3'b000) begin
            n_bad++; $display("FAIL abort_state: busy/hold/done got %b want 000", {busy, core_hold, done});
        end
        n_cmp++;
        if (words_loaded !== 9'd1) begin n_bad++; $display("FAIL abort_words: got %0d want 1", words_loaded); end
        repeat (2) @(negedge clk);
        n_cmp++;
        if (wr_addr.size() !== 1 || wr_data[0] !== 32'h44332211) begin
            n_bad++; $display("FAIL abort_writes: got %0d writes want 1 of 44332211", wr_addr.size());
        end
        n_cmp++;
        if (byte_ready !== 1'b0) begin n_bad++; $display("FAIL abort_ready: got %b want 0", byte_ready); end
        clear_log();
        start_load(9'd1);
        send_word(32'hDDCCBBAA, 1'b0, o);
        byte_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (wr_addr.size() !== 1 || wr_addr[0] !== 8'h00 || wr_data[0] !== 32'hDDCCBBAA) begin
            n_bad++; $display("FAIL abort_restart: got %0d writes, first %h/%h want 1, 00/ddccbbaa",
                              wr_addr.size(), (wr_addr.size() > 0) ? wr_addr[0] : 8'hxx, (wr_data.size() > 0) ? wr_data[0] : 32'hx);
        end
        n_cmp++;
        if ({done, words_loaded} !== {1'b1, 9'd1}) begin
            n_bad++; $display("FAIL abort_restart_done: got %b/%0d want 1/1", done, words_loaded);
        end
    endtask

    task automatic test_abort_edges();
        bit o;
        // Abort coincident with the WRITE cycle: write happens, count does not advance.
        clear_log();
        start_load(9'd2);
        send_word(32'hCAFEF00D, 1'b0, o);
        byte_valid = 1'b0;
        n_cmp++;
        if (mem_we !== 1'b1) begin n_bad++; $display("FAIL abortw_we: got %b want 1", mem_we); end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (wr_addr.size() !== 1 || wr_data[0] !== 32'hCAFEF00D) begin
            n_bad++; $display("FAIL abortw_write: got %0d writes want 1 of cafef00d", wr_addr.size());
        end
        n_cmp++;
        if ({words_loaded, busy, core_hold} !== {9'd0, 2'b00}) begin
            n_bad++; $display("FAIL abortw_state: words/busy/hold got %0d/%b%b want 0/00", words_loaded, busy, core_hold);
        end
        // Abort in the same cycle as the last byte: byte dropped, no write.
        clear_log();
        start_load(9'd1);
        send_byte(8'h01, o);
        send_byte(8'h02, o);
        send_byte(8'h03, o);
        byte_in = 8'h77;
        byte_valid = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        byte_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (wr_addr.size() !== 0) begin n_bad++; $display("FAIL abortb_nowrite: got %0d want 0", wr_addr.size()); end
        n_cmp++;
        if ({busy, done, words_loaded} !== {2'b00, 9'd0}) begin
            n_bad++; $display("FAIL abortb_state: busy/done/words got %b%b/%0d want 00/0", busy, done, words_loaded);
        end
    endtask

    task automatic test_full_depth();
        bit o;
        bit all_ok;
        int bad_entries;
        int taken;
        logic [7:0] b;
        all_ok = 1'b1;
        clear_log();
        start_load(9'd256);
        for (int i = 0; i < 256; i++) begin
            b = 8'(i);
            send_word({b, b, b, b}, 1'b0, o);
            if (!o) all_ok = 1'b0;
        end
        byte_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (all_ok !== 1'b1) begin n_bad++; $display("FAIL full_accept: got %b want 1", all_ok); end
        n_cmp++;
        if (wr_addr.size() !== 256) begin n_bad++; $display("FAIL full_count: got %0d want 256", wr_addr.size()); end
        else begin
            n_cmp++;
            if (wr_addr[255] !== 8'hFF || wr_data[255] !== 32'hFFFFFFFF) begin
                n_bad++; $display("FAIL full_last: got %h/%h want ff/ffffffff", wr_addr[255], wr_data[255]);
            end
            bad_entries = 0;
            for (int i = 0; i < 256; i++) begin
                b = 8'(i);
                if (wr_addr[i] !== b || wr_data[i] !== {b, b, b, b}) bad_entries++;
            end
            n_cmp++;
            if (bad_entries !== 0) begin n_bad++; $display("FAIL full_pattern: got %0d bad entries want 0", bad_entries); end
        end
        n_cmp++;
        if ({done, words_loaded} !== {1'b1, 9'd256}) begin
            n_bad++; $display("FAIL full_done: got %b/%0d want 1/256", done, words_loaded);
        end
        taken = 0;
        byte_in = 8'h5A;
        byte_valid = 1'b1;
        repeat (5) begin
            if (byte_ready !== 1'b0) taken++;
            @(negedge clk);
        end
        byte_valid = 1'b0;
        n_cmp++;
        if (taken !== 0) begin n_bad++; $display("FAIL full_done_ready: got %0d ready cycles want 0", taken); end
        n_cmp++;
        if (wr_addr.size() !== 256 || words_loaded !== 9'd256) begin
            n_bad++; $display("FAIL full_done_stable: got %0d writes/%0d words want 256/256", wr_addr.size(), words_loaded);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_three_toggle();
        test_bad_len();
        test_abort();
        test_abort_edges();
        test_full_depth();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
